// File: rtl/hop_seq_pkg.sv
// Shared state encoding and lane-selection helper for the hop-chain test sequencer.
package hop_seq_pkg;

  localparam int MAX_LANES = 32;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LAUNCH,
    WAIT,
    DONE
  } hop_state_e;

  // Returns MAX_LANES when no bit is set, so a zero mask selects no lane.
  function automatic int lowest_set_idx(input logic [MAX_LANES-1:0] mask);
    int idx;
    idx = MAX_LANES;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/hop_lat_counter.sv
// Saturating launch-to-exit latency counter with synchronous clear and a timeout flag.
module hop_lat_counter #(
  parameter int LAT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clock0,
  input  logic             rst0_n,
  input  logic             clr,
  input  logic             en,
  output logic [LAT_W-1:0] cnt,
  output logic             at_timeout
);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  assign at_timeout = (cnt_q == LAT_W'(TIMEOUT));
  assign cnt        = cnt_q;

  // Holding at TIMEOUT keeps a dead lane from wrapping back into a plausible latency.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !at_timeout) begin
      cnt_d = cnt_q + LAT_W'(1);
    end
  end

  always_ff @(posedge clock0) begin
    if (!rst0_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hop_chain_sequencer.sv
// Per-lane clear/launch/measure sequencer for the multi-lane hop flop-chain benches.
module hop_chain_sequencer
  import hop_seq_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int DEPTH   = 4,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 15,
  parameter int LAT_W   = 4
) (
  input  logic                   clock0,
  input  logic                   rst0_n,
  input  logic                   run,
  input  logic [LANES-1:0]       lane_mask,
  output logic [LANES-1:0]       start,
  output logic [LANES*DEPTH-1:0] stage_rst,
  input  logic [LANES-1:0]       lane_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [LANES-1:0]       err_lane,
  output logic [LAT_W-1:0]       lat_last
);

  localparam int CLR_W = (CLR_CYC > 2) ? $clog2(CLR_CYC) : 1;

  hop_state_e             state_q, state_d;
  logic [LANES-1:0]       mask_q, mask_d;
  logic [LANES-1:0]       err_q, err_d;
  logic [LANES-1:0]       start_q, start_d;
  logic [LANES*DEPTH-1:0] stage_rst_q, stage_rst_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [LAT_W-1:0]       lat_last_q, lat_last_d;
  logic [CLR_W-1:0]       clr_cnt_q, clr_cnt_d;

  logic [LANES-1:0]       sel;
  int                     lane_idx;
  logic                   lane_hit;
  logic                   wait_exit;
  logic                   cnt_clr;
  logic                   cnt_en;
  logic                   at_timeout;
  logic [LAT_W-1:0]       cnt;

  // The lane under test is always the lowest bit still pending in the mask.
  always_comb begin
    sel      = '0;
    lane_idx = lowest_set_idx(MAX_LANES'(mask_q));
    for (int j = 0; j < LANES; j++) begin
      sel[j] = (j == lane_idx);
    end
  end

  assign lane_hit  = |(lane_out & sel);
  assign wait_exit = (state_q == WAIT) && (lane_hit || at_timeout);
  assign cnt_clr   = (state_d == LAUNCH);
  assign cnt_en    = (state_q == LAUNCH) || ((state_q == WAIT) && !wait_exit);

  hop_lat_counter #(
    .LAT_W   (LAT_W),
    .TIMEOUT (TIMEOUT)
  ) u_lat_counter (
    .clock0     (clock0),
    .rst0_n     (rst0_n),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .cnt        (cnt),
    .at_timeout (at_timeout)
  );

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    err_d      = err_q;
    pass_d     = pass_q;
    lat_last_d = lat_last_q;
    clr_cnt_d  = clr_cnt_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          mask_d    = lane_mask;
          err_d     = '0;
          clr_cnt_d = '0;
          state_d   = (lane_mask == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CLR_W'(CLR_CYC - 1)) begin
          state_d = LAUNCH;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Any other lane toggling while this one is measured is cross-lane leakage.
        err_d = err_q | (lane_out & ~sel);
        if (wait_exit) begin
          lat_last_d = cnt;
          if (at_timeout || (cnt != LAT_W'(DEPTH))) begin
            err_d = err_d | sel;
          end
          mask_d    = mask_q & ~sel;
          clr_cnt_d = '0;
          state_d   = (mask_d == '0) ? DONE : CLEAR;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin-facing outputs are decoded from the next state so they change only on a clock edge.
  always_comb begin
    busy_d      = (state_d != IDLE);
    start_d     = (state_d == LAUNCH) ? sel : '0;
    stage_rst_d = (state_d == CLEAR) ? '1 : '0;
  end

  always_ff @(posedge clock0) begin
    if (!rst0_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      err_q       <= '0;
      start_q     <= '0;
      stage_rst_q <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      lat_last_q  <= '0;
      clr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      err_q       <= err_d;
      start_q     <= start_d;
      stage_rst_q <= stage_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      lat_last_q  <= lat_last_d;
      clr_cnt_q   <= clr_cnt_d;
    end
  end

  assign start     = start_q;
  assign stage_rst = stage_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_lane  = err_q;
  assign lat_last  = lat_last_q;

endmodule
